// File: rtl/ysyx_22051013_ifu.sv
// Instruction fetch stage: owns the PC, issues one imem fetch at a time, holds the result for IF/ID.
// Optional static branch prediction on the held instruction is enabled by defining IFU_STATIC_BP_EN.
module ysyx_22051013_ifu #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              bpu_jump
);

    // Handshakes: a request transfers on a cycle with imem_req_valid & imem_req_ready; the held
    // instruction retires on if_valid & id_ready. Valid never drops and the address/payload never
    // change while waiting for ready, except when ex_redirect flushes the stage.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [INST_W-1:0]   if_inst_q;
    logic [ADDR_W-1:0]   if_pc_q;
    logic                latch;
    logic [ADDR_W-1:0]   next_pc;

`ifdef IFU_STATIC_BP_EN
    logic              is_jal;
    logic              is_bwd_br;
    logic [ADDR_W-1:0] imm_j;
    logic [ADDR_W-1:0] imm_b;

    assign is_jal    = (if_inst_q[6:0] == 7'b1101111);
    assign is_bwd_br = (if_inst_q[6:0] == 7'b1100011) && if_inst_q[31];
    assign imm_j = {{(ADDR_W-21){if_inst_q[31]}}, if_inst_q[31], if_inst_q[19:12],
                    if_inst_q[20], if_inst_q[30:21], 1'b0};
    assign imm_b = {{(ADDR_W-13){if_inst_q[31]}}, if_inst_q[31], if_inst_q[7],
                    if_inst_q[30:25], if_inst_q[11:8], 1'b0};

    always_comb begin
        next_pc = pc_q + ADDR_W'(4);
        if (is_jal) begin
            next_pc = pc_q + imm_j;
        end else if (is_bwd_br) begin
            next_pc = pc_q + imm_b;
        end
    end

    assign bpu_jump = is_jal | is_bwd_br;
`else
    assign next_pc  = pc_q + ADDR_W'(4);
    assign bpu_jump = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = drop_q ? S_REQ : S_OUT;
                    latch   = !drop_q;
                    drop_d  = 1'b0;
                end
            end
            S_OUT: begin
                if (id_ready) begin
                    state_d = S_REQ;
                    pc_d    = next_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A redirect with no response yet leaves a stale fetch in flight; wait it out with drop set.
        if (ex_redirect) begin
            pc_d  = ex_redirect_pc;
            latch = 1'b0;
            if (state_q == S_WAIT && !imem_resp_valid) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            if_inst_q <= '0;
            if_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (latch) begin
                if_inst_q <= imem_resp_data;
                if_pc_q   <= pc_q;
            end
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == S_OUT);
    assign if_inst        = if_inst_q;
    assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_ysyx_22051013_ifu.sv
// Bench for ysyx_22051013_ifu: directed scenarios then randomized traffic, checked by a
// reference model and expected-instruction queue in a monitor decoupled from the drivers.
module tb_ysyx_22051013_ifu;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int ITEM_W = 97;  // {pc, inst, jump}
`ifdef IFU_STATIC_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ex_redirect;
  logic [63:0] ex_redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        bpu_jump;

  int n_checks = 0;
  int n_fail = 0;
  int n_hs = 0;

  ysyx_22051013_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .bpu_jump       (bpu_jump)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference prediction: returns {jump, next_pc}, immediates assembled arithmetically.
  function automatic logic [64:0] ref_next(input logic [63:0] pc, input logic [31:0] inst);
    longint imm;
    logic [64:0] r;
    r = {1'b0, pc + 64'd4};
    if (BP_EN) begin
      if (inst[6:0] == 7'b1101111) begin
        imm = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048 + longint'(inst[19:12]) * 4096;
        if (inst[31]) imm = imm - 1048576;
        r = {1'b1, pc + 64'(imm)};
      end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
        imm = longint'(inst[11:8]) * 2 + longint'(inst[30:25]) * 32 + longint'(inst[7]) * 2048 - 4096;
        r = {1'b1, pc + 64'(imm)};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: return 32'h0000_0013;
      1: return {v[31:7], 7'b1101111};
      2: return {1'b1, v[30:7], 7'b1100011};
      3: return {1'b0, v[30:7], 7'b1100011};
      default: return v;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit rdir, input logic [63:0] rpc, input bit idr);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    ex_redirect     = rdir;
    ex_redirect_pc  = rpc;
    id_ready        = idr;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
  endtask

  // ---------------- reference model + scoreboard monitor ----------------
  logic [ITEM_W-1:0] exp_q[$];
  logic [63:0]       ref_pc = RESET_PC;
  bit                outstanding = 1'b0;
  bit                live = 1'b0;
  bit                idle_pending = 1'b1;
  bit                prev_rst = 1'b0;

  always @(negedge clk) begin
    logic [64:0] r;
    logic [ITEM_W-1:0] item;
    bit exp_rv;
    #2;
    if (prev_rst) begin
      chk("reset_state", 128'({imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, bpu_jump}),
          128'({1'b0, RESET_PC, 1'b0, 32'h0, 64'h0, 1'b0}));
    end
    if (rst) begin
      exp_q.delete();
      ref_pc       = RESET_PC;
      outstanding  = 1'b0;
      live         = 1'b0;
      idle_pending = 1'b1;
      prev_rst     = 1'b1;
    end else begin
      prev_rst = 1'b0;
      exp_rv = !idle_pending && !outstanding && (exp_q.size() == 0);
      chk("if_valid", 128'(if_valid), 128'(exp_q.size() != 0));
      if (if_valid && exp_q.size() != 0)
        chk("if_out", 128'({if_pc, if_inst, bpu_jump}), 128'(exp_q[0]));
      chk("req_valid", 128'(imem_req_valid), 128'(exp_rv));
      if (imem_req_valid)
        chk("req_addr", 128'(imem_req_addr), 128'(ref_pc));
      // Model the event committed at the coming edge.
      if (ex_redirect) begin
        if (outstanding && imem_resp_valid) outstanding = 1'b0;
        live = 1'b0;
        exp_q.delete();
        ref_pc = ex_redirect_pc;
        idle_pending = 1'b0;
      end else if (idle_pending) begin
        idle_pending = 1'b0;
      end else if (exp_rv && imem_req_ready) begin
        outstanding = 1'b1;
        live = 1'b1;
      end else if (outstanding && imem_resp_valid) begin
        outstanding = 1'b0;
        if (live) begin
          r = ref_next(ref_pc, imem_resp_data);
          exp_q.push_back({ref_pc, imem_resp_data, r[64]});
        end
        live = 1'b0;
      end else if (exp_q.size() != 0 && id_ready) begin
        item = exp_q.pop_front();
        r = ref_next(item[96:33], item[32:1]);
        ref_pc = r[63:0];
        n_hs++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          pend;
    int          delay;
    bit          rdy, rv, rdir, idr;
    logic [31:0] rd;
    logic [63:0] rpc;

    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    ex_redirect = 1'b0;
    ex_redirect_pc = 64'h0;
    id_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic fetch: idle cycle, accept, response next cycle, retire.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 64'h0, 1'b0);
    chk("first_if_pc", 128'(if_pc), 128'(64'h8000_0000));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    chk("second_addr", 128'({imem_req_valid, imem_req_addr}), 128'({1'b1, 64'h8000_0004}));

    // Memory stalls the request for three cycles.
    repeat (3) idle_cyc();
    chk("stall_addr", 128'({imem_req_valid, imem_req_addr}), 128'({1'b1, 64'h8000_0004}));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0010_0093, 1'b0, 64'h0, 1'b0);

    // IF/ID back-pressure for five cycles.
    repeat (5) idle_cyc();
    chk("held_out", 128'({if_valid, if_pc, if_inst, imem_req_valid}),
        128'({1'b1, 64'h8000_0004, 32'h0010_0093, 1'b0}));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    chk("req_after_hold", 128'({imem_req_valid, imem_req_addr}), 128'({1'b1, 64'h8000_0008}));

    // Redirect while waiting; the late response must be dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_1000, 1'b0);
    idle_cyc();
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 64'h0, 1'b1);
    chk("drop_resp", 128'({if_valid, imem_req_valid, imem_req_addr}),
        128'({1'b0, 1'b1, 64'h8000_1000}));

    // Redirect in the same cycle as a retire handshake.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_2000, 1'b1);
    chk("redirect_out", 128'({if_valid, imem_req_valid, imem_req_addr}),
        128'({1'b0, 1'b1, 64'h8000_2000}));

    // Backward branch at 8000_0010.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0010, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b1, 32'hFE00_0EE3, 1'b0, 64'h0, 1'b0);
    chk("bp_jump", 128'({if_pc, bpu_jump}), 128'({64'h8000_0010, BP_EN}));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    chk("bp_next_addr", 128'(imem_req_addr), 128'(BP_EN ? 64'h8000_000C : 64'h8000_0014));

    // Randomized traffic with a mid-run reset.
    n_hs = 0;
    pend = 1'b0;
    delay = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = (i == 1500 || i == 1501);
      rdy  = ($urandom_range(0, 3) != 0) && !pend;
      rv   = 1'b0;
      rd   = rand_inst();
      if (pend) begin
        if (delay == 0) begin
          rv = 1'b1;
          pend = 1'b0;
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rv = 1'b1;
      end
      rdir = ($urandom_range(0, 11) == 0);
      rpc  = RESET_PC + 64'({$urandom_range(0, 4095), 2'b00});
      idr  = ($urandom_range(0, 9) < 7);
      if (!rst && imem_req_valid && rdy && !rdir) begin
        pend = 1'b1;
        delay = $urandom_range(0, 3);
      end
      drive(rdy, rv, rd, rdir, rpc, idr);
    end
    rst = 1'b0;
    repeat (2) idle_cyc();
    chk("random_progress", 128'(n_hs >= 20), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
